// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: time-multiplexed stereo mixer for PSG sound cards.
//
// Each sample strobe snapshots the channel samples and the per-channel
// gain/route config. It then runs one multiply-accumulate per clock over
// all channels and produces saturated left/right outputs with a one-cycle
// valid pulse.
//
// Ports:
//   clk_logic       system logic clock
//   system_reset_n  synchronous active-low reset
//   sample_stb_i    single-cycle pulse, starts a mix pass (accepted only when idle)
//   ch_data_i       packed unsigned samples, channel k at [k*IN_W +: IN_W]
//   cfg_wr_i        config write strobe
//   cfg_addr_i      channel index being written (>= NUM_CH: gain/route ignored)
//   cfg_data_i      [3:0] gain (8 = unity), [4] route L, [5] route R,
//                   [6] clear overrun, [7] clear peaks (peak build only)
//   audio_l_o/_r_o  registered mixed samples, held between passes
//   valid_o         one-cycle pulse when the audio outputs update
//   busy_o          high while a pass is in progress
//   overrun_o       sticky, a strobe arrived while busy
//   peak_l_o/_r_o   running peak of the audio outputs (PSG_MIXER_PEAK_EN only)
//
// Optional feature macro: PSG_MIXER_PEAK_EN adds the peak-hold outputs.
module psg_stereo_mixer #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned OUT_W  = 10,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_logic,
  input  logic                   system_reset_n,
  input  logic                   sample_stb_i,
  input  logic [NUM_CH*IN_W-1:0] ch_data_i,
  input  logic                   cfg_wr_i,
  input  logic [CH_W-1:0]        cfg_addr_i,
  input  logic [7:0]             cfg_data_i,
  output logic [OUT_W-1:0]       audio_l_o,
  output logic [OUT_W-1:0]       audio_r_o,
  output logic                   valid_o,
  output logic                   busy_o,
`ifdef PSG_MIXER_PEAK_EN
  output logic [OUT_W-1:0]       peak_l_o,
  output logic [OUT_W-1:0]       peak_r_o,
`endif
  output logic                   overrun_o
);

  localparam int unsigned ProdW = IN_W + 4;
  // NUM_CH <= 2^CH_W, so CH_W extra bits cover the full sum without overflow.
  localparam int unsigned AccW  = ProdW + CH_W;
  localparam int unsigned SatW  = ((AccW > OUT_W) ? AccW : OUT_W) + 1;
  localparam logic [SatW-1:0] OutMax = SatW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [AccW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]  audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // Live config.
  logic [3:0]        gain_q [NUM_CH];
  logic [3:0]        gain_d [NUM_CH];
  logic              rte_l_q [NUM_CH];
  logic              rte_l_d [NUM_CH];
  logic              rte_r_q [NUM_CH];
  logic              rte_r_d [NUM_CH];

  // Per-pass snapshot.
  logic [IN_W-1:0]   sh_data_q [NUM_CH];
  logic [IN_W-1:0]   sh_data_d [NUM_CH];
  logic [3:0]        sh_gain_q [NUM_CH];
  logic [3:0]        sh_gain_d [NUM_CH];
  logic              sh_l_q [NUM_CH];
  logic              sh_l_d [NUM_CH];
  logic              sh_r_q [NUM_CH];
  logic              sh_r_d [NUM_CH];

`ifdef PSG_MIXER_PEAK_EN
  logic [OUT_W-1:0]  peak_l_q, peak_l_d, peak_r_q, peak_r_d;
`else
  logic              unused_cfg_bit7;
  assign unused_cfg_bit7 = cfg_data_i[7];
`endif

  logic [IN_W-1:0]   cur_data;
  logic [3:0]        cur_gain;
  logic              cur_l, cur_r;
  logic [ProdW-1:0]  prod;
  logic [AccW-1:0]   sum_l, sum_r;

  function automatic logic [OUT_W-1:0] saturate(input logic [AccW-1:0] acc);
    logic [SatW-1:0] s;
    s = SatW'(acc >> 3);
    return (s > OutMax) ? {OUT_W{1'b1}} : s[OUT_W-1:0];
  endfunction

  // Channel selected by the pass index.
  always_comb begin
    cur_data = '0;
    cur_gain = '0;
    cur_l    = 1'b0;
    cur_r    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == CH_W'(k)) begin
        cur_data = sh_data_q[k];
        cur_gain = sh_gain_q[k];
        cur_l    = sh_l_q[k];
        cur_r    = sh_r_q[k];
      end
    end
    prod  = ProdW'(cur_data) * ProdW'(cur_gain);
    sum_l = cur_l ? acc_l_q + AccW'(prod) : acc_l_q;
    sum_r = cur_r ? acc_r_q + AccW'(prod) : acc_r_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    gain_d    = gain_q;
    rte_l_d   = rte_l_q;
    rte_r_d   = rte_r_q;
    sh_data_d = sh_data_q;
    sh_gain_d = sh_gain_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;

    if (cfg_wr_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_addr_i == CH_W'(k)) begin
          gain_d[k]  = cfg_data_i[3:0];
          rte_l_d[k] = cfg_data_i[4];
          rte_r_d[k] = cfg_data_i[5];
        end
      end
      if (cfg_data_i[6]) overrun_d = 1'b0;
    end
    // Set after clear so a simultaneous overrun wins.
    if (sample_stb_i && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_stb_i) begin
          // Snapshot uses the pre-write config, so a same-cycle write misses this pass.
          for (int k = 0; k < NUM_CH; k++) begin
            sh_data_d[k] = ch_data_i[k*IN_W +: IN_W];
            sh_gain_d[k] = gain_q[k];
            sh_l_d[k]    = rte_l_q[k];
            sh_r_d[k]    = rte_r_q[k];
          end
          idx_d   = '0;
          acc_l_d = '0;
          acc_r_d = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        idx_d   = idx_q + CH_W'(1);
        if (idx_q == CH_W'(NUM_CH - 1)) begin
          // Register the result on entry to StOut so it is visible during StOut.
          audio_l_d = saturate(sum_l);
          audio_r_d = saturate(sum_r);
          valid_d   = 1'b1;
          idx_d     = '0;
          state_d   = StOut;
        end
      end
      StOut: begin
        acc_l_d = '0;
        acc_r_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PSG_MIXER_PEAK_EN
  always_comb begin
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (valid_q) begin
      if (audio_l_q > peak_l_q) peak_l_d = audio_l_q;
      if (audio_r_q > peak_r_q) peak_r_d = audio_r_q;
    end
    if (cfg_wr_i && cfg_data_i[7]) begin
      peak_l_d = '0;
      peak_r_d = '0;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l_o = peak_l_q;
  assign peak_r_o = peak_r_q;
`endif

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        gain_q[k]    <= 4'd8;
        // Small configs are mono-to-both; otherwise 0..2 left, rest right.
        rte_l_q[k]   <= (NUM_CH <= 3) || (k < 3);
        rte_r_q[k]   <= (NUM_CH <= 3) || (k >= 3);
        sh_data_q[k] <= '0;
        sh_gain_q[k] <= '0;
        sh_l_q[k]    <= 1'b0;
        sh_r_q[k]    <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      gain_q    <= gain_d;
      rte_l_q   <= rte_l_d;
      rte_r_q   <= rte_r_d;
      sh_data_q <= sh_data_d;
      sh_gain_q <= sh_gain_d;
      sh_l_q    <= sh_l_d;
      sh_r_q    <= sh_r_d;
    end
  end

  assign audio_l_o = audio_l_q;
  assign audio_r_o = audio_r_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != StIdle);
  assign overrun_o = overrun_q;

endmodule
